// File: rtl/cpu_step_display.sv
//------------------------------------------------------------------------------
// cpu_step_display
//
// Board-level front end for the single-cycle CPU core.
//
//  * Step path: the raw step push-button is synchronised and debounced. The
//    debounced level is the CPU core clock, so one clean press produces one
//    rising edge on cpu_clk, which executes one instruction.
//  * Display path: a free-running refresh counter scans a 4-digit multiplexed
//    seven-segment display in the order 3,2,1,0. At the start of every frame
//    (the tick that selects digit 3) a 16-bit word is captured from the CPU
//    observation signals. The page is chosen by sel, and the whole frame is
//    drawn from that one snapshot, so input changes never tear a frame.
//
// Ports
//   clk         in   1   board clock
//   RST         in   1   asynchronous active-low reset
//   step_btn    in   1   raw, bouncy, asynchronous push-button
//   sel         in   2   display page select (sampled at snapshot)
//   pc          in  32   current PC
//   newpc       in  32   next PC
//   rs          in   5   source register number
//   rd1         in  32   ReadData1
//   rt          in   5   target register number
//   rd2         in  32   ReadData2
//   alu_result  in  32   ALU result
//   db_data     in  32   register write-back data
//   cpu_clk     out  1   clock to the CPU core (debounced button level)
//   pos_ctrl    out  4   digit enables, active-low one-hot, bit 3 = leftmost
//   num_ctrl    out  8   segments, active-low, bit 7 = dp (always off)
//------------------------------------------------------------------------------
module cpu_step_display #(
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        step_btn,
   input  logic [1:0]  sel,
   input  logic [31:0] pc,
   input  logic [31:0] newpc,
   input  logic [4:0]  rs,
   input  logic [31:0] rd1,
   input  logic [4:0]  rt,
   input  logic [31:0] rd2,
   input  logic [31:0] alu_result,
   input  logic [31:0] db_data,
   output logic        cpu_clk,
   output logic [3:0]  pos_ctrl,
   output logic [7:0]  num_ctrl
);

   //---------------------------------------------------------------------------
   // Widths and terminal counts
   //---------------------------------------------------------------------------
   localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RFW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RFW-1:0] REF_LAST = RFW'(REFRESH_DIV - 1);

   //---------------------------------------------------------------------------
   // Seven-segment glyphs, active-low, dp off (bit 7 = 1)
   //---------------------------------------------------------------------------
   function automatic logic [7:0] seg7(input logic [3:0] nib);
      logic [7:0] seg;
      seg = 8'hFF;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         4'hF: seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
      return seg;
   endfunction

   //---------------------------------------------------------------------------
   // Step button: 2-flop synchroniser + debounce counter
   //---------------------------------------------------------------------------
   logic [1:0]     r_sync;
   logic           r_deb;
   logic [DBW-1:0] r_db_cnt;
   logic           w_sync_lvl;
   logic           w_db_diff;

   assign w_sync_lvl = r_sync[1];
   assign w_db_diff  = (w_sync_lvl != r_deb);

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_sync   <= 2'b00;
         r_deb    <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], step_btn};
         if (!w_db_diff) begin
            // Any return to agreement restarts the stability window.
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_deb    <= w_sync_lvl;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
         end
      end
   end

   // The debounced register itself drives the core clock: no extra stage, so
   // the press-to-edge latency is exactly DEBOUNCE_CYCLES+2 clk edges.
   assign cpu_clk = r_deb;

   //---------------------------------------------------------------------------
   // Refresh counter and scan index
   //---------------------------------------------------------------------------
   logic [RFW-1:0] r_ref_cnt;
   logic [1:0]     r_idx;
   logic           w_tick;
   logic [1:0]     w_idx_next;

   assign w_tick     = (r_ref_cnt == REF_LAST);
   assign w_idx_next = r_idx - 2'd1;   // wraps 0 -> 3

   //---------------------------------------------------------------------------
   // Snapshot word selection
   //---------------------------------------------------------------------------
   logic [15:0] r_word;
   logic [15:0] w_capture;
   logic [15:0] w_frame;
   logic        w_new_frame;

   always_comb begin
      w_capture = 16'h0000;
      case (sel)
         2'b00:   w_capture = {pc[7:0], newpc[7:0]};
         2'b01:   w_capture = {3'b000, rs, rd1[7:0]};
         2'b10:   w_capture = {3'b000, rt, rd2[7:0]};
         default: w_capture = {alu_result[7:0], db_data[7:0]};
      endcase
   end

   // Digit 3 on the capture edge must already show the freshly captured word.
   assign w_new_frame = (w_idx_next == 2'd3);
   assign w_frame     = w_new_frame ? w_capture : r_word;

   // Split the frame into per-digit nibbles and glyphs.
   logic [3:0] w_nibble [4];
   logic [7:0] w_glyph  [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign w_nibble[gi] = w_frame[4*gi +: 4];
         assign w_glyph[gi]  = seg7(w_nibble[gi]);
      end
   endgenerate

   logic [3:0] w_pos_next;
   logic [7:0] w_num_next;

   assign w_pos_next = ~(4'b0001 << w_idx_next);
   assign w_num_next = w_glyph[w_idx_next];

   //---------------------------------------------------------------------------
   // Refresh / display registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_ref_cnt <= '0;
         r_idx     <= 2'd0;
         r_word    <= 16'h0000;
         pos_ctrl  <= 4'b1111;
         num_ctrl  <= 8'hFF;
      end else begin
         if (w_tick) begin
            r_ref_cnt <= '0;
            r_idx     <= w_idx_next;
            pos_ctrl  <= w_pos_next;
            num_ctrl  <= w_num_next;
            if (w_new_frame) begin
               r_word <= w_capture;
            end
         end else begin
            r_ref_cnt <= r_ref_cnt + RFW'(1);
         end
      end
   end

   // Only the low byte of the wide observation buses is displayed.
   logic w_unused;
   assign w_unused = &{1'b0, pc[31:8], newpc[31:8], rd1[31:8], rd2[31:8],
                       alu_result[31:8], db_data[31:8]};

endmodule

// File: tb/tb_cpu_step_display.sv
module tb_cpu_step_display;

   logic        clk;
   logic        RST;
   logic        step_btn;
   logic [1:0]  sel;
   logic [31:0] pc;
   logic [31:0] newpc;
   logic [4:0]  rs;
   logic [31:0] rd1;
   logic [4:0]  rt;
   logic [31:0] rd2;
   logic [31:0] alu_result;
   logic [31:0] db_data;
   logic        cpu_clk;
   logic [3:0]  pos_ctrl;
   logic [7:0]  num_ctrl;

   int total = 0;
   int bad   = 0;

   cpu_step_display #(
      .REFRESH_DIV     (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .step_btn   (step_btn),
      .sel        (sel),
      .pc         (pc),
      .newpc      (newpc),
      .rs         (rs),
      .rd1        (rd1),
      .rt         (rt),
      .rd2        (rd2),
      .alu_result (alu_result),
      .db_data    (db_data),
      .cpu_clk    (cpu_clk),
      .pos_ctrl   (pos_ctrl),
      .num_ctrl   (num_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Wait one refresh period (4 edges) and check the digit just lit.
   task automatic digit(input string tag, input logic [3:0] pos_exp, input logic [7:0] num_exp);
      repeat (4) @(negedge clk);
      chk({tag, "_pos"}, {28'd0, pos_ctrl}, {28'd0, pos_exp});
      chk({tag, "_num"}, {24'd0, num_ctrl}, {24'd0, num_exp});
   endtask

   initial begin
      RST        = 1'b0;
      step_btn   = 1'b0;
      sel        = 2'b00;
      pc         = 32'h0000_0004;
      newpc      = 32'h0000_0008;
      rs         = 5'd17;
      rd1        = 32'h0000_002F;
      rt         = 5'd3;
      rd2        = 32'h0000_0055;
      alu_result = 32'h0000_00AB;
      db_data    = 32'h0000_00CD;

      // ---------------- reset state ----------------
      @(negedge clk);
      chk("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      chk("rst_pos", {28'd0, pos_ctrl}, 32'hF);
      chk("rst_num", {24'd0, num_ctrl}, 32'hFF);
      RST = 1'b1;

      // blank for REFRESH_DIV-1 edges, first tick on edge 4
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("blank_pos", {28'd0, pos_ctrl}, 32'hF);
         chk("blank_num", {24'd0, num_ctrl}, 32'hFF);
      end
      @(negedge clk);
      chk("d3_pos", {28'd0, pos_ctrl}, 32'h7);
      chk("d3_num", {24'd0, num_ctrl}, 32'hC0);

      // ---------------- scan/decode, word 0408 ----------------
      digit("d2", 4'b1011, 8'h99);
      digit("d1", 4'b1101, 8'hC0);
      digit("d0", 4'b1110, 8'h80);
      digit("d3r", 4'b0111, 8'hC0);

      // ---------------- page select mid-frame: no effect until next frame
      sel = 2'b01;
      digit("p_old_d2", 4'b1011, 8'h99);
      digit("p_old_d1", 4'b1101, 8'hC0);
      digit("p_old_d0", 4'b1110, 8'h80);
      digit("p_d3", 4'b0111, 8'hF9);
      digit("p_d2", 4'b1011, 8'hF9);
      digit("p_d1", 4'b1101, 8'hA4);
      digit("p_d0", 4'b1110, 8'h8E);
      sel = 2'b00;

      // ---------------- no tearing ----------------
      digit("t_d3", 4'b0111, 8'hC0);
      digit("t_d2", 4'b1011, 8'h99);
      pc = 32'h0000_00FF;   // changed while digit 2 lit
      digit("t_d1", 4'b1101, 8'hC0);
      digit("t_d0", 4'b1110, 8'h80);
      digit("t_new_d3", 4'b0111, 8'h8E);
      digit("t_new_d2", 4'b1011, 8'h8E);
      digit("t_new_d1", 4'b1101, 8'hC0);
      digit("t_new_d0", 4'b1110, 8'h80);

      // ---------------- debounce: 5-cycle glitch ----------------
      step_btn = 1'b1;
      repeat (5) @(negedge clk);
      step_btn = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk("glitch_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      end

      // ---------------- steady press: rises on edge 10 ----------------
      step_btn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("press_e%0d", k), {31'd0, cpu_clk}, (k >= 10) ? 32'd1 : 32'd0);
      end

      // ---------------- steady release: falls on edge 10 ----------------
      step_btn = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("rel_e%0d", k), {31'd0, cpu_clk}, (k >= 10) ? 32'd0 : 32'd1);
      end

      // ---------------- reset mid-press ----------------
      step_btn = 1'b1;
      repeat (12) @(negedge clk);
      chk("pre_rst_cpu_clk", {31'd0, cpu_clk}, 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("arst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      chk("arst_pos", {28'd0, pos_ctrl}, 32'hF);
      chk("arst_num", {24'd0, num_ctrl}, 32'hFF);
      @(negedge clk);
      RST = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("rp_e%0d", k), {31'd0, cpu_clk}, (k >= 10) ? 32'd1 : 32'd0);
         if (k <= 3) begin
            chk("rp_blank_pos", {28'd0, pos_ctrl}, 32'hF);
            chk("rp_blank_num", {24'd0, num_ctrl}, 32'hFF);
         end
         if (k == 4) begin
            chk("rp_d3_pos", {28'd0, pos_ctrl}, 32'h7);
            chk("rp_d3_num", {24'd0, num_ctrl}, 32'h8E);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
